shared_bus_arbiter: RTL and testbench
=====================================

SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 1: max transfers per grant; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset is asynchronous and active-high.
REQ-004 REQ  input  4  request per requester; bit i = requester i; held high until served.
REQ-005 INPUT1, INPUT2, INPUT3, INPUT4  input  32 each  data from requesters 0..3.
REQ-006 OUT_READY  input  1  downstream accepts RESULT this cycle.
REQ-007 GNT  output  4  one-hot grant, registered.
REQ-008 SELECT  output  2  index of granted requester, registered; drives the shared 4:1 32-bit mux select.
REQ-009 RESULT  output  32  INPUT(SELECT+1), combinational from SELECT.
REQ-010 OUT_VALID  output  1  RESULT valid to downstream.

Function
REQ-011 The block SHALL implement two states, IDLE and BUSY, plus a 2-bit round-robin pointer PTR and a 4-bit beat counter BEATS.
REQ-012 In IDLE with REQ==0, the block SHALL stay in IDLE with GNT=0000 and OUT_VALID=0; SELECT SHALL hold its last value.
REQ-013 In IDLE with REQ!=0, the block SHALL choose the first set bit scanning PTR, PTR+1, PTR+2, PTR+3 (mod 4).
REQ-014 On that same edge it SHALL load GNT (one-hot) and SELECT with the winner, clear BEATS, and enter BUSY; GNT is visible one cycle after REQ is sampled.
REQ-015 In BUSY, OUT_VALID SHALL equal REQ[SELECT] (combinational); GNT SHALL stay constant.
REQ-016 A transfer SHALL occur on each edge where OUT_VALID=1 and OUT_READY=1; each transfer increments BEATS.
REQ-017 The grant SHALL end on the edge where a transfer makes BEATS reach BURST_LEN.
REQ-018 The grant SHALL also end on any BUSY edge where REQ[SELECT]=0; no transfer is counted on that edge.
REQ-019 On grant end the block SHALL set PTR=SELECT+1 (mod 4), clear GNT to 0000, and return to IDLE.
REQ-020 There SHALL always be exactly one IDLE cycle between consecutive grants (no back-to-back grants).
REQ-021 A requester dropping REQ in the same cycle as a transfer is impossible by REQ-015 (OUT_VALID=0); the drop SHALL end the grant per REQ-018.
REQ-022 OUT_READY held low in BUSY SHALL stall indefinitely with GNT, SELECT and RESULT stable; there is no timeout.
REQ-023 Requests from non-granted requesters arriving or dropping during BUSY SHALL have no effect until the next IDLE evaluation.
REQ-024 GNT SHALL be zero or one-hot at all times; OUT_VALID SHALL be 0 whenever GNT=0000.

Reset
REQ-025 While RESET=1, independent of CLK: state=IDLE, GNT=0000, SELECT=00, PTR=00, BEATS=0, OUT_VALID=0.
REQ-026 RESET mid-burst SHALL abort the grant immediately with no transfer counted; PTR SHALL return to 00, not advance.
REQ-027 On the first edge after RESET falls, arbitration SHALL proceed per REQ-013 with PTR=00.

Verification
REQ-028 After reset, REQ=0100, OUT_READY=1, BURST_LEN=1 -> next cycle GNT=0100, SELECT=10, OUT_VALID=1, RESULT=INPUT3; one cycle later GNT=0000; PTR=11.
REQ-029 REQ=1111 held, OUT_READY=1, BURST_LEN=1 -> grants in order 0001,0010,0100,1000,0001, each separated by one IDLE cycle.
REQ-030 BURST_LEN=3, REQ=0010, OUT_READY pattern 1,0,1,1 -> exactly 3 transfers over 4 BUSY cycles, RESULT=INPUT2 throughout, then IDLE.
REQ-031 BURST_LEN=4, granted requester 0 drops REQ after 2 transfers -> OUT_VALID=0 that cycle, grant ends, PTR=01; REQ=1001 pending -> requester 3 granted next.
REQ-032 RESET asserted asynchronously mid-cycle during BUSY with SELECT=11 -> GNT=0000, SELECT=00, OUT_VALID=0 before the next edge; after release with REQ=1001 -> requester 0 granted.

Source files
------------

// File: rtl/shared_bus_arbiter_if.sv
// Bus between four requesters, the round-robin arbiter and the downstream sink.
// The arbiter takes the slave view; whatever drives requests and data takes the master view.
interface shared_bus_arbiter_if;
   logic [3:0]  req;
   logic [31:0] input1;
   logic [31:0] input2;
   logic [31:0] input3;
   logic [31:0] input4;
   logic        out_ready;
   logic [3:0]  gnt;
   logic [1:0]  select;
   logic [31:0] result;
   logic        out_valid;

   modport master (
      output req, input1, input2, input3, input4, out_ready,
      input  gnt, select, result, out_valid
   );

   modport slave (
      input  req, input1, input2, input3, input4, out_ready,
      output gnt, select, result, out_valid
   );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Four-way round-robin arbiter that owns a shared 4:1 32-bit data mux.
// Each grant lasts up to BURST_LEN transfers and is followed by one idle cycle.
module shared_bus_arbiter #(
   parameter int BURST_LEN = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   shared_bus_arbiter_if.slave   bus
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] beats_last = 4'(BURST_LEN);

   state_t      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  sel_q, sel_d;
   logic [3:0]  beats_q, beats_d;
   logic [3:0]  gnt_q, gnt_d;
   logic [1:0]  winner;
   logic        owner_req;
   logic        grant_end;
   logic        valid;

   // Scan from the highest offset down so the nearest requester at or after ptr wins.
   always_comb begin
      winner = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (bus.req[2'(ptr_q + 2'(k))]) winner = 2'(ptr_q + 2'(k));
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      beats_d   = beats_q;
      gnt_d     = gnt_q;
      valid     = 1'b0;
      grant_end = 1'b0;
      owner_req = bus.req[sel_q];

      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = BUSY;
               sel_d   = winner;
               gnt_d   = 4'b0001 << winner;
               beats_d = 4'd0;
            end
         end
         BUSY: begin
            valid = owner_req;
            if (!owner_req) begin
               grant_end = 1'b1;
            end else if (bus.out_ready) begin
               beats_d = beats_q + 4'd1;
               if (beats_q + 4'd1 == beats_last) grant_end = 1'b1;
            end
            if (grant_end) begin
               state_d = IDLE;
               ptr_d   = sel_q + 2'd1;
               gnt_d   = 4'b0000;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         beats_q <= 4'd0;
         gnt_q   <= 4'b0000;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         beats_q <= beats_d;
         gnt_q   <= gnt_d;
      end
   end

   always_comb begin
      case (sel_q)
         2'd0:    bus.result = bus.input1;
         2'd1:    bus.result = bus.input2;
         2'd2:    bus.result = bus.input3;
         default: bus.result = bus.input4;
      endcase
   end

   assign bus.gnt       = gnt_q;
   assign bus.select    = sel_q;
   assign bus.out_valid = valid;
endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Scoreboard bench: two arbiters (burst 3 and burst 1) share stimulus; a per-grant
// reference model predicts each cycle's outputs and a negedge monitor compares them.
module tb_shared_bus_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   shared_bus_arbiter_if bus_a ();
   shared_bus_arbiter_if bus_b ();

   shared_bus_arbiter #(.BURST_LEN(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   shared_bus_arbiter #(.BURST_LEN(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   typedef struct {
      bit busy;
      int owner;
      int ptr;
      int beats;
   } model_t;

   typedef struct {
      logic [3:0]  gnt;
      logic [1:0]  sel;
      logic        valid;
      logic [31:0] result;
   } exp_t;

   exp_t        q_a[$];
   exp_t        q_b[$];
   exp_t        ea, eb;
   model_t      m_a = '{0, 0, 0, 0};
   model_t      m_b = '{0, 0, 0, 0};
   logic [3:0]  req = 4'b0000;
   logic        ready = 1'b0;
   logic [31:0] din [4];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Outputs seen during the current cycle, given what the model says owns the bus.
   function automatic exp_t predict(input model_t m);
      exp_t e;
      if (rst) begin
         e.gnt = 4'b0000; e.sel = 2'd0; e.valid = 1'b0; e.result = din[0];
      end else begin
         e.gnt    = m.busy ? 4'(1 << m.owner) : 4'b0000;
         e.sel    = 2'(m.owner);
         e.valid  = m.busy && req[m.owner];
         e.result = din[m.owner];
      end
      return e;
   endfunction

   // What the clock edge ending this cycle does to the grant bookkeeping.
   function automatic model_t advance(input model_t m, input int burst);
      model_t n = m;
      bit done = 0;
      if (rst) return '{0, 0, 0, 0};
      if (!m.busy) begin
         if (req != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
               if (req[(m.ptr + i) % 4]) begin
                  n.owner = (m.ptr + i) % 4;
                  break;
               end
            end
            n.busy  = 1;
            n.beats = 0;
         end
      end else begin
         if (!req[m.owner]) done = 1;
         else if (ready) begin
            n.beats = m.beats + 1;
            if (n.beats == burst) done = 1;
         end
         if (done) begin
            n.busy = 0;
            n.ptr  = (m.owner + 1) % 4;
         end
      end
      return n;
   endfunction

   task automatic apply();
      bus_a.req = req;  bus_a.out_ready = ready;
      bus_b.req = req;  bus_b.out_ready = ready;
      bus_a.input1 = din[0]; bus_a.input2 = din[1]; bus_a.input3 = din[2]; bus_a.input4 = din[3];
      bus_b.input1 = din[0]; bus_b.input2 = din[1]; bus_b.input3 = din[2]; bus_b.input4 = din[3];
   endtask

   // One clock cycle of stimulus; mid asserts reset asynchronously inside the cycle.
   task automatic cycle(input logic [3:0] r, input bit rd, input bit rs, input bit mid);
      @(posedge clk);
      #1;
      req   = r;
      ready = rd;
      for (int i = 0; i < 4; i++) din[i] = $urandom;
      apply();
      if (mid) begin
         #1 rst = 1'b1;
      end else begin
         rst = rs;
      end
      #1;
      q_a.push_back(predict(m_a));
      q_b.push_back(predict(m_b));
      m_a = advance(m_a, 3);
      m_b = advance(m_b, 1);
   endtask

   task automatic compare(input string tag, input exp_t e, input logic [3:0] g,
                          input logic [1:0] s, input logic v, input logic [31:0] r);
      check({tag, ".gnt"}, 32'(g), 32'(e.gnt));
      check({tag, ".select"}, 32'(s), 32'(e.sel));
      check({tag, ".out_valid"}, 32'(v), 32'(e.valid));
      check({tag, ".result"}, r, e.result);
      check({tag, ".gnt_onehot0"}, 32'($onehot0(g)), 32'd1);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (q_a.size() != 0) begin
            ea = q_a.pop_front();
            compare("a", ea, bus_a.gnt, bus_a.select, bus_a.out_valid, bus_a.result);
         end
         if (q_b.size() != 0) begin
            eb = q_b.pop_front();
            compare("b", eb, bus_b.gnt, bus_b.select, bus_b.out_valid, bus_b.result);
         end
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) din[i] = 32'h0;
      apply();
      cycle(4'b0000, 1'b0, 1'b1, 1'b0);
      cycle(4'b0000, 1'b0, 1'b1, 1'b0);
      // single request from requester 2
      cycle(4'b0100, 1'b1, 1'b0, 1'b0);
      cycle(4'b0100, 1'b1, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      // all four requesting: rotation with idle gaps
      for (int i = 0; i < 12; i++) cycle(4'b1111, 1'b1, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      // burst of three with one stall in the middle
      cycle(4'b0010, 1'b1, 1'b0, 1'b0);
      cycle(4'b0010, 1'b1, 1'b0, 1'b0);
      cycle(4'b0010, 1'b0, 1'b0, 1'b0);
      cycle(4'b0010, 1'b1, 1'b0, 1'b0);
      cycle(4'b0010, 1'b1, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      // requester 0 drops after two transfers while requester 3 waits
      cycle(4'b0001, 1'b1, 1'b0, 1'b0);
      cycle(4'b0001, 1'b1, 1'b0, 1'b0);
      cycle(4'b0001, 1'b1, 1'b0, 1'b0);
      cycle(4'b1000, 1'b1, 1'b0, 1'b0);
      cycle(4'b1001, 1'b1, 1'b0, 1'b0);
      cycle(4'b1001, 1'b1, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      // requester 3 granted, long stall, then asynchronous reset mid-cycle
      cycle(4'b1000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(4'b1000, 1'b0, 1'b0, 1'b0);
      cycle(4'b1000, 1'b0, 1'b0, 1'b1);
      cycle(4'b1001, 1'b1, 1'b0, 1'b0);
      cycle(4'b1001, 1'b1, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0, 1'b0);
      // randomized traffic with occasional mid-cycle resets
      for (int i = 0; i < 600; i++) begin
         cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b0,
               ($urandom_range(0, 79) == 0));
      end
      cycle(4'b0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("scoreboard_a_drained", 32'(q_a.size()), 32'd0);
      check("scoreboard_b_drained", 32'(q_b.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
